// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT245 FIFO bridge.
package ftdi_pkg;

  localparam int unsigned FTDI_BUS_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_RELEASE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    TURN
  } ftdi_state_e;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } ftdi_dir_e;

endpackage

// File: rtl/ftdi_fifo_bridge_if.sv
// Core-side valid/ready streams and FIFO levels of the FT245 bridge.
interface ftdi_fifo_bridge_if #(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) ();

  logic [ftdi_pkg::FTDI_BUS_W-1:0] rx_data;
  logic                            rx_valid;
  logic                            rx_ready;
  logic [ftdi_pkg::FTDI_BUS_W-1:0] tx_data;
  logic                            tx_valid;
  logic                            tx_ready;
  logic [$clog2(RX_DEPTH):0]       rx_level;
  logic [$clog2(TX_DEPTH):0]       tx_level;

  modport master (
    input  rx_data, rx_valid, tx_ready, rx_level, tx_level,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, rx_level, tx_level,
    input  rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/ftdi_sync_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full from empty.
module ftdi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;
  // Gated so the head reads zero whenever nothing is stored.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// FT245 parallel FIFO bridge with RX/TX FIFOs and round-robin strobe FSM.
// Optional byte counters are enabled by defining FTDI_BRIDGE_CNT_EN.
module ftdi_fifo_bridge
  import ftdi_pkg::*;
#(
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RD_PULSE    = 2,
  parameter int unsigned WR_PULSE    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  inout  wire  [FTDI_BUS_W-1:0] io_245,
  input  logic                  txe_245,
  input  logic                  rxf_245_in,
  output logic                  rx_245_out,
  output logic                  wr_245,
  ftdi_fifo_bridge_if.slave     core
`ifdef FTDI_BRIDGE_CNT_EN
  ,
  output logic [31:0]           rx_count,
  output logic [31:0]           tx_count
`endif
);

  localparam logic [15:0] RD_LAST = 16'(RD_PULSE - 1);
  localparam logic [15:0] WR_LAST = 16'(WR_PULSE - 1);

  logic [SYNC_STAGES-1:0] r_txe_sync;
  logic [SYNC_STAGES-1:0] r_rxf_sync;
  ftdi_state_e            r_state;
  ftdi_dir_e              r_last_dir;
  logic [15:0]            r_cnt;
  logic                   r_rd_n;
  logic                   r_wr_n;
  logic                   r_oe;
  logic [FTDI_BUS_W-1:0]  r_dout;

  logic                   w_txe_s;
  logic                   w_rxf_s;
  logic                   w_rx_full;
  logic                   w_rx_empty;
  logic                   w_tx_full;
  logic                   w_tx_empty;
  logic [FTDI_BUS_W-1:0]  w_rx_head;
  logic [FTDI_BUS_W-1:0]  w_tx_head;
  logic                   w_rx_elig;
  logic                   w_tx_elig;
  logic                   w_pick_rx;
  logic                   w_pick_tx;
  logic                   w_rx_push;
  logic                   w_tx_pop;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_txe_sync <= '1;
      r_rxf_sync <= '1;
    end else begin
      r_txe_sync <= {r_txe_sync[SYNC_STAGES-2:0], txe_245};
      r_rxf_sync <= {r_rxf_sync[SYNC_STAGES-2:0], rxf_245_in};
    end
  end

  assign w_txe_s = r_txe_sync[SYNC_STAGES-1];
  assign w_rxf_s = r_rxf_sync[SYNC_STAGES-1];

  ftdi_sync_fifo #(
    .WIDTH (FTDI_BUS_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_push  (w_rx_push),
    .i_wdata (io_245),
    .i_pop   (core.rx_ready),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (core.rx_level)
  );

  ftdi_sync_fifo #(
    .WIDTH (FTDI_BUS_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk   (clock_in),
    .i_rst_n (reset_n),
    .i_push  (core.tx_valid),
    .i_wdata (core.tx_data),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (core.tx_level)
  );

  assign core.rx_data  = w_rx_head;
  assign core.rx_valid = !w_rx_empty;
  assign core.tx_ready = !w_tx_full;

  // On a tie, serve whichever direction was not served last.
  assign w_rx_elig = !w_rxf_s && !w_rx_full;
  assign w_tx_elig = !w_txe_s && !w_tx_empty;
  assign w_pick_rx = w_rx_elig && (!w_tx_elig || (r_last_dir == DIR_TX));
  assign w_pick_tx = w_tx_elig && !w_pick_rx;

  assign w_rx_push = (r_state == RD_STROBE) && (r_cnt == RD_LAST);
  assign w_tx_pop  = (r_state == IDLE) && w_pick_tx;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_last_dir <= DIR_TX;
      r_cnt      <= '0;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_dout     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pick_rx) begin
            r_state    <= RD_STROBE;
            r_rd_n     <= 1'b0;
            r_last_dir <= DIR_RX;
          end else if (w_pick_tx) begin
            r_state    <= WR_SETUP;
            r_oe       <= 1'b1;
            r_dout     <= w_tx_head;
            r_last_dir <= DIR_TX;
          end
        end
        RD_STROBE: begin
          if (r_cnt == RD_LAST) begin
            r_state <= RD_RELEASE;
            r_rd_n  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RD_RELEASE: r_state <= TURN;
        WR_SETUP: begin
          r_state <= WR_STROBE;
          r_wr_n  <= 1'b0;
        end
        WR_STROBE: begin
          if (r_cnt == WR_LAST) begin
            r_state <= WR_HOLD;
            r_wr_n  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR_HOLD: begin
          r_state <= TURN;
          r_oe    <= 1'b0;
        end
        TURN: r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_rd_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign rx_245_out = r_rd_n;
  assign wr_245     = r_wr_n;
  assign io_245     = r_oe ? r_dout : {FTDI_BUS_W{1'bz}};

`ifdef FTDI_BRIDGE_CNT_EN
  logic [31:0] r_rx_count;
  logic [31:0] r_tx_count;

  // wr_245 falls exactly on the WR_SETUP -> WR_STROBE transition.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_count <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_rx_push)            r_rx_count <= r_rx_count + 1'b1;
      if (r_state == WR_SETUP)  r_tx_count <= r_tx_count + 1'b1;
    end
  end

  assign rx_count = r_rx_count;
  assign tx_count = r_tx_count;
`endif

endmodule

// File: doc/ftdi_fifo_bridge.md
# ftdi_fifo_bridge

Parametrised FT245-style parallel FIFO bridge between the FTDI USB chip and the Mercurial core logic. It owns the shared 8-bit bidirectional bus and buffers each direction in an internal synchronous FIFO of configurable depth. It exposes valid/ready streams to the core, replacing the single-byte request/strobe handshake. Strobe widths are programmable, and RX/TX arbitration is round-robin, so neither direction starves.

## Interface
- RX_DEPTH, 16: RX FIFO depth in bytes; power of 2, minimum 2.
- TX_DEPTH, 16: TX FIFO depth in bytes; power of 2, minimum 2.
- RD_PULSE, 2: cycles rx_245_out is held low before io_245 is sampled; minimum 1.
- WR_PULSE, 2: cycles wr_245 is held low; minimum 1.
- SYNC_STAGES, 2: synchroniser depth for txe_245 and rxf_245_in; minimum 2.
- clock_in  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_245  inout  8  FTDI data bus; driven only while oe is high, otherwise Z.
- txe_245  in  1  FTDI; 0 = can accept a byte for the PC.
- rxf_245_in  in  1  FTDI; 0 = byte from the PC available.
- rx_245_out  out  1  FTDI read strobe, active low.
- wr_245  out  1  FTDI write strobe; byte latched on falling edge.
- rx_data  out  8  head of RX FIFO (show-ahead).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  core pops rx_data when rx_valid && rx_ready.
- tx_data  in  8  byte from the core to send to the PC.
- tx_valid  in  1  core offers tx_data.
- tx_ready  out  1  TX FIFO not full; push when tx_valid && tx_ready.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.

## Operation
- txe_245 and rxf_245_in pass through SYNC_STAGES flops, reset to 1. The FSM uses only the synchronised copies (txe_s, rxf_s).
- Eligibility:
  - RX eligible = !rxf_s && RX FIFO not full.
  - TX eligible = !txe_s && TX FIFO not empty.
- Arbitration in IDLE:
  - If exactly one direction is eligible, serve it.
  - If both are eligible, serve the direction not served last. The last_dir flag resets to TX, so RX wins the first tie.
- FSM states, strobe-side:
  - IDLE: strobes high, oe=0.
  - RD_STROBE: rx_245_out=0 for RD_PULSE cycles. On the last cycle, io_245 is sampled and pushed into the RX FIFO.
  - RD_RELEASE: rx_245_out=1 for 1 cycle.
  - TURN: 1 cycle, strobes high, oe=0, then IDLE.
- FSM states, write side:
  - WR_SETUP: oe=1, io_245 = TX FIFO head, wr_245=1, 1 cycle. The FIFO is popped on entry to this state.
  - WR_STROBE: wr_245=0 for WR_PULSE cycles.
  - WR_HOLD: wr_245=1, oe=1, 1 cycle, then TURN.
- The bus is driven only in WR_SETUP, WR_STROBE and WR_HOLD. oe and rx_245_out are never low/high-active together.
- FIFO boundaries:
  - Simultaneous push and pop on either FIFO is allowed; the level is unchanged.
  - A push into a full FIFO is impossible by construction: the RX side is gated by eligibility, the TX side by tx_ready.
  - A pop from an empty FIFO is ignored.
  - Pointers wrap modulo depth, with one extra bit to distinguish full from empty.
- Eligibility is sampled only in IDLE. A transfer in progress always completes even if the FTDI flags change.
- Reset (reset_n low, at any time):
  - State returns to IDLE; FIFOs are emptied; an in-flight byte is lost.
  - rx_245_out=1, wr_245=1, oe=0 (io_245 Z).
  - rx_valid=0, rx_data=0, tx_ready=1, rx_level=0, tx_level=0.

## Timing
- Flag latency: an FTDI flag change is visible to the FSM SYNC_STAGES cycles later.
- Read transaction: IDLE to IDLE is RD_PULSE+2 cycles. The byte appears on rx_valid the cycle after it is sampled.
- Write transaction: WR_PULSE+3 cycles.
- Core-side TX latency: a byte pushed at cycle N is at the TX FIFO head at N+1. The earliest wr_245 falling edge is at N+3, with txe_s already low and the FSM in IDLE.
- All FTDI-facing outputs are registered, so there are no combinational paths from FTDI pins to FTDI pins.
- Core-side flags: rx_valid and tx_ready come directly from FIFO registers, so there is no combinational path from rx_ready or tx_valid.

## Configuration
- FTDI_BRIDGE_CNT_EN defined:
  - Adds outputs rx_count and tx_count, 32-bit each.
  - rx_count increments per byte pushed into the RX FIFO; tx_count increments per wr_245 falling edge.
  - Both wrap at 2^32 and reset to 0.
- FTDI_BRIDGE_CNT_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package ftdi_pkg holds:
  - FTDI_BUS_W = 8.
  - The FSM state enum: IDLE, RD_STROBE, RD_RELEASE, WR_SETUP, WR_STROBE, WR_HOLD, TURN.
  - The direction type used for last_dir.
- Sub-module ftdi_sync_fifo: parameters WIDTH and DEPTH; push/pop interface with full, empty and level. It is instantiated twice (RX and TX).
- The top level holds the synchronisers, arbiter, FSM, tristate buffer and optional counters.

## Test plan
- Single read: rxf_245_in=0, the FTDI model presents 0xA5; RD_PULSE=2. Expect rx_245_out low for exactly 2 cycles, then rx_valid=1 with rx_data=0xA5 and rx_level=1.
- Single write: push 0x3C with txe_245=0. Expect oe high, io_245=0x3C stable through WR_STROBE, wr_245 low for WR_PULSE cycles, and tx_level back to 0.
- Round-robin: both directions held eligible with 4 bytes each. Expect FTDI transfers in the order RX, TX, RX, TX, RX, TX, RX, TX, and the bus never driven during an RD_STROBE.
- RX full: rx_ready=0 and the FTDI sends RX_DEPTH+3 bytes. Expect exactly RX_DEPTH reads, then rx_245_out stays high. Popping one byte allows exactly one more read.
- Reset mid-write: assert reset_n low during WR_STROBE. Expect wr_245=1, io_245=Z, tx_ready=1 and both levels 0 without waiting for a clock edge.
- With FTDI_BRIDGE_CNT_EN: 5 reads and 7 writes. Expect rx_count=5 and tx_count=7.
